// File: rtl/audio_pingpong_buffer.sv
// Ping-pong sample buffer: read data appears 1 cycle after rd_req_i; the producer stalls (wr_ready_o=0) while the back bank is full.
// Optional PPBUF_REPEAT_EN: reads during underrun replay the front bank instead of returning 0.
module audio_pingpong_buffer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int CH_LOG2    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_valid_i,
  input  logic [DATA_W-1:0]                      wr_data_i,
  output logic                                   wr_ready_o,
  input  logic                                   rd_req_i,
  output logic                                   rd_valid_o,
  output logic [DATA_W-1:0]                      rd_data_o,
  output logic [((CH_LOG2 > 0) ? CH_LOG2 : 1)-1:0] rd_ch_o,
  output logic [DEPTH_LOG2-1:0]                  rd_frame_o,
  output logic                                   buffer_sel_o,
  output logic                                   filled_o,
  output logic                                   underrun_o,
  output logic [15:0]                            underrun_cnt_o
);

  localparam int CHW   = (CH_LOG2 > 0) ? CH_LOG2 : 1;
  localparam int AW    = DEPTH_LOG2 + CH_LOG2;
  localparam int WORDS = 2 * (1 << AW);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_RUN    = 2'd1,
    S_STARVE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [DATA_W-1:0]  mem [WORDS];
  logic [AW-1:0]      wcnt, rcnt;
  logic [AW:0]        raddr;
  logic [CHW-1:0]     cur_ch;
  logic [DEPTH_LOG2-1:0] cur_frame;
  logic               wr_fire, swap, rd_zero, adv, count_ur;

  assign wr_ready_o = ~filled_o;
  assign wr_fire    = wr_valid_i & ~filled_o;
  assign underrun_o = (state == S_STARVE);
  assign raddr      = {buffer_sel_o, rcnt};
  assign cur_frame  = rcnt[AW-1:CH_LOG2];

  generate
    if (CH_LOG2 > 0) begin : g_ch
      assign cur_ch = rcnt[CH_LOG2-1:0];
    end else begin : g_no_ch
      assign cur_ch = '0;
    end
  endgenerate

  always_comb begin
    next_state = state;
    swap       = 1'b0;
    rd_zero    = 1'b0;
    adv        = 1'b0;
    count_ur   = 1'b0;
    case (state)
      S_WAIT: begin
        rd_zero = 1'b1;
        if (filled_o) begin
          swap       = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (rd_req_i) begin
          adv = 1'b1;
          // A final write landing together with the final read is not yet
          // visible in filled_o, so that case falls into STARVE for one cycle.
          if (&rcnt) begin
            if (filled_o) swap = 1'b1;
            else          next_state = S_STARVE;
          end
        end
      end
      S_STARVE: begin
        count_ur = rd_req_i;
`ifdef PPBUF_REPEAT_EN
        adv      = rd_req_i;
`else
        rd_zero  = 1'b1;
`endif
        if (filled_o) begin
          swap       = 1'b1;
          next_state = S_RUN;
        end
      end
      default: next_state = S_WAIT;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{~buffer_sel_o, wcnt}] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_WAIT;
      buffer_sel_o   <= 1'b0;
      filled_o       <= 1'b0;
      wcnt           <= '0;
      rcnt           <= '0;
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
      rd_ch_o        <= '0;
      rd_frame_o     <= '0;
      underrun_cnt_o <= '0;
    end else begin
      state      <= next_state;
      rd_valid_o <= rd_req_i;

      if (wr_fire) begin
        wcnt <= wcnt + 1'b1;
        if (&wcnt) filled_o <= 1'b1;
      end

      // Swap only happens with filled_o set, so it never coincides with a write.
      if (swap) begin
        buffer_sel_o <= ~buffer_sel_o;
        filled_o     <= 1'b0;
        wcnt         <= '0;
        rcnt         <= '0;
      end else if (adv) begin
        rcnt <= rcnt + 1'b1;
      end

      if (rd_req_i) begin
        rd_data_o  <= rd_zero ? '0 : mem[raddr];
        rd_ch_o    <= cur_ch;
        rd_frame_o <= cur_frame;
      end

      if (count_ur && (underrun_cnt_o != 16'hFFFF))
        underrun_cnt_o <= underrun_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_pingpong_buffer.sv
// Directed bench for audio_pingpong_buffer with 8 words per bank (2 channels x 4 frames).
module tb_audio_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid_i;
  logic [15:0] wr_data_i;
  logic        wr_ready_o;
  logic        rd_req_i;
  logic        rd_valid_o;
  logic [15:0] rd_data_o;
  logic [0:0]  rd_ch_o;
  logic [1:0]  rd_frame_o;
  logic        buffer_sel_o;
  logic        filled_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  audio_pingpong_buffer #(.DATA_W(16), .DEPTH_LOG2(2), .CH_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .rd_ch_o(rd_ch_o), .rd_frame_o(rd_frame_o),
    .buffer_sel_o(buffer_sel_o), .filled_o(filled_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " sel"},      buffer_sel_o, 0);
    check({tag, " filled"},   filled_o, 0);
    check({tag, " ready"},    wr_ready_o, 1);
    check({tag, " rvalid"},   rd_valid_o, 0);
    check({tag, " rdata"},    rd_data_o, 0);
    check({tag, " rch"},      rd_ch_o, 0);
    check({tag, " rframe"},   rd_frame_o, 0);
    check({tag, " underrun"}, underrun_o, 0);
    check({tag, " ur_cnt"},   underrun_cnt_o, 0);
  endtask

  // Continuous reads starting from frame 0; expected data is base, base+1, ...
  task automatic read_seq(input string tag, input int n, input int base);
    rd_req_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, " rvalid"}, rd_valid_o, 1);
      check({tag, " rdata"},  rd_data_o, 32'(base + i));
      check({tag, " rch"},    rd_ch_o, 32'(i % 2));
      check({tag, " rframe"}, rd_frame_o, 32'((i / 2) % 4));
    end
    rd_req_i = 1'b0;
  endtask

  task automatic write_seq(input int n, input int base);
    wr_valid_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data_i = 16'(base + i);
      step();
    end
    wr_valid_i = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    rd_req_i   = 1'b0;

    // Reset state and a read while waiting for the first bank
    step(); step();
    check_reset_values("reset");
    rst_n = 1'b1;
    step();
    rd_req_i = 1'b1;
    step();
    rd_req_i = 1'b0;
    check("wait rvalid", rd_valid_o, 1);
    check("wait rdata", rd_data_o, 0);
    step();
    check("wait rvalid pulse", rd_valid_o, 0);
    check("wait ur_cnt", underrun_cnt_o, 0);

    // First fill 1..8 into bank 1, then the swap
    write_seq(8, 1);
    check("fill1 filled", filled_o, 1);
    check("fill1 ready", wr_ready_o, 0);
    check("fill1 sel before swap", buffer_sel_o, 0);
    step();
    check("swap1 sel", buffer_sel_o, 1);
    check("swap1 filled", filled_o, 0);
    check("swap1 ready", wr_ready_o, 1);

    // Producer fills back bank with 9..16, then stalls on 17
    write_seq(8, 9);
    check("bp filled", filled_o, 1);
    wr_valid_i = 1'b1;
    wr_data_i  = 16'd17;
    step(); step();
    check("bp ready held low", wr_ready_o, 0);
    check("bp sel", buffer_sel_o, 1);

    // Drain 1..8 while 17 is still offered; last read swaps
    read_seq("drain1", 8, 1);
    check("swap2 sel", buffer_sel_o, 0);
    check("swap2 filled", filled_o, 0);
    check("swap2 ready", wr_ready_o, 1);
    check("swap2 underrun", underrun_o, 0);
    write_seq(8, 17);
    check("fill3 filled", filled_o, 1);

    // Read 9..24 across a swap, then fall into underrun
    read_seq("drain2", 16, 9);
    check("starve sel", buffer_sel_o, 1);
    check("starve underrun", underrun_o, 1);
    check("starve ur_cnt0", underrun_cnt_o, 0);
    rd_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("starve rvalid", rd_valid_o, 1);
`ifdef PPBUF_REPEAT_EN
      check("starve rdata", rd_data_o, 32'(17 + i));
`else
      check("starve rdata", rd_data_o, 0);
`endif
    end
    rd_req_i = 1'b0;
    step();
    check("starve ur_cnt3", underrun_cnt_o, 3);
    check("starve underrun held", underrun_o, 1);

    // Refill 25..32 while starving: swap without counting
    write_seq(8, 25);
    check("refill filled", filled_o, 1);
    step();
    check("refill sel", buffer_sel_o, 0);
    check("refill underrun", underrun_o, 0);
    check("refill ur_cnt", underrun_cnt_o, 3);

    // Final write and final read in the same cycle
    rd_req_i   = 1'b1;
    wr_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data_i = 16'(33 + i);
      step();
      check("sim rdata", rd_data_o, 32'(25 + i));
    end
    rd_req_i   = 1'b0;
    wr_valid_i = 1'b0;
    check("sim underrun", underrun_o, 1);
    check("sim filled", filled_o, 1);
    check("sim sel", buffer_sel_o, 0);
    step();
    check("sim swap sel", buffer_sel_o, 1);
    check("sim swap underrun", underrun_o, 0);
    check("sim swap filled", filled_o, 0);
    check("sim ur_cnt", underrun_cnt_o, 3);
    read_seq("sim next bank", 8, 33);
    check("sim end underrun", underrun_o, 1);

    // Mid-operation reset: 5 writes with 3 underrun reads, then reset with a read in flight
    wr_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data_i = 16'(41 + i);
      rd_req_i  = (i < 3);
      step();
    end
    wr_valid_i = 1'b0;
    check("pre-reset ur_cnt", underrun_cnt_o, 6);
    rd_req_i = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_values("mid reset");
    rd_req_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Normal fill after reset
    write_seq(8, 51);
    check("post fill filled", filled_o, 1);
    step();
    check("post swap sel", buffer_sel_o, 1);
    check("post swap filled", filled_o, 0);
    read_seq("post read", 2, 51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
